// File: rtl/ats_timer_bank.sv
// ats_timer_bank
//   Bank of NUM_CLOCKS free-running counters (step +1/+2/+4 per clk) and
//   NUM_ALARMS alarm / countdown-timer slots. Each slot is bound to one
//   counter and can auto-reload. The bank is driven through one req/ready
//   command port. Each accepted command takes IDLE -> EXEC -> RESP.
//
// Ports
//   clk      : single clock, every flop on posedge
//   reset_n  : asynchronous active-low reset
//   req      : command request, sampled only while ready=1
//   ctrl_a   : [15:12] op, [11:6] index, [5:2] clock select, [1:0] rate/loop
//   ctrl_b   : operand (load value, alarm value, timer interval)
//   ready    : high in IDLE
//   stat     : 00 none, 01 ok, 10 error, 11 read data valid (one cycle, RESP)
//   rdata    : counter value for CLK_READ, otherwise 0
//   data     : data[i] = flag of alarm i, held FLAG_HOLD cycles after a fire
//   irq      : only with ATS_IRQ_EN, sticky "some alarm fired" bit
//
// Build option
//   ATS_IRQ_EN : adds the irq output and opcode 9 (IRQ_ACK). Without it,
//                opcode 9 returns error.
module ats_timer_bank #(
    parameter int CLK_W      = 16,
    parameter int NUM_CLOCKS = 16,
    parameter int NUM_ALARMS = 24,
    parameter int FLAG_HOLD  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic [15:0]           ctrl_a,
    input  logic [CLK_W-1:0]      ctrl_b,
    output logic                  ready,
    output logic [1:0]            stat,
    output logic [CLK_W-1:0]      rdata,
    output logic [NUM_ALARMS-1:0] data
`ifdef ATS_IRQ_EN
    ,
    output logic                  irq
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_CLK_START = 4'd1;
    localparam logic [3:0] OP_CLK_STOP  = 4'd2;
    localparam logic [3:0] OP_CLK_LOAD  = 4'd3;
    localparam logic [3:0] OP_CLK_READ  = 4'd4;
    localparam logic [3:0] OP_ALM_SET   = 4'd5;
    localparam logic [3:0] OP_TMR_SET   = 4'd6;
    localparam logic [3:0] OP_ALM_CLR   = 4'd7;
    localparam logic [3:0] OP_SOFT_RST  = 4'd8;
`ifdef ATS_IRQ_EN
    localparam logic [3:0] OP_IRQ_ACK   = 4'd9;
`endif
    localparam logic [3:0] HOLD_INIT    = 4'(FLAG_HOLD);

    state_t state, state_nxt;

    logic [15:0]      cmd_a;
    logic [CLK_W-1:0] cmd_b;
    logic [3:0]       cmd_op;
    logic [5:0]       cmd_idx;
    logic [3:0]       cmd_csel;
    logic [1:0]       cmd_rl;

    logic [CLK_W-1:0]      cnt      [NUM_CLOCKS];
    logic [1:0]            cnt_rate [NUM_CLOCKS];
    logic [CLK_W-1:0]      cnt_step [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] cnt_en;
    logic [NUM_CLOCKS-1:0] cnt_adv;
    logic [NUM_CLOCKS-1:0] sel_clk;

    logic [NUM_ALARMS-1:0] alm_en, alm_loop, alm_tmr, alm_adv, sel_alm, fire;
    logic [CLK_W-1:0]      alm_val  [NUM_ALARMS];
    logic [CLK_W-1:0]      alm_int  [NUM_ALARMS];
    logic [CLK_W-1:0]      alm_old  [NUM_ALARMS];
    logic [CLK_W-1:0]      alm_step [NUM_ALARMS];
    logic [CLK_W-1:0]      alm_diff [NUM_ALARMS];
    logic [3:0]            alm_clk  [NUM_ALARMS];
    logic [3:0]            alm_hold [NUM_ALARMS];

    logic             idx_clk_ok, idx_alm_ok, csel_ok, cmd_ok, exec_ok, cnt_override;
    logic [CLK_W-1:0] idx_cnt, src_cnt;
    logic [1:0]       resp_stat;

    assign cmd_op   = cmd_a[15:12];
    assign cmd_idx  = cmd_a[11:6];
    assign cmd_csel = cmd_a[5:2];
    assign cmd_rl   = cmd_a[1:0];

    // Command FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Command FSM next state; the block only listens to req while idle.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (req) state_nxt = ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Decode the captured command: one-hot targets, operand counters,
    // legality and the response code. Illegal commands touch no state.
    always_comb begin
        sel_clk = '0;
        sel_alm = '0;
        idx_cnt = '0;
        src_cnt = '0;
        for (int c = 0; c < NUM_CLOCKS; c++) begin
            sel_clk[c] = (cmd_idx == 6'(c));
            if (cmd_idx == 6'(c))  idx_cnt = cnt[c];
            if (cmd_csel == 4'(c)) src_cnt = cnt[c];
        end
        for (int a = 0; a < NUM_ALARMS; a++) begin
            sel_alm[a] = (cmd_idx == 6'(a));
        end
        idx_clk_ok = 32'(cmd_idx) < NUM_CLOCKS;
        idx_alm_ok = 32'(cmd_idx) < NUM_ALARMS;
        csel_ok    = 32'(cmd_csel) < NUM_CLOCKS;
        case (cmd_op)
            OP_NOP:       cmd_ok = 1'b1;
            OP_CLK_START: cmd_ok = idx_clk_ok && (cmd_rl != 2'd3);
            OP_CLK_STOP,
            OP_CLK_LOAD,
            OP_CLK_READ:  cmd_ok = idx_clk_ok;
            OP_ALM_SET:   cmd_ok = idx_alm_ok && csel_ok;
            OP_TMR_SET:   cmd_ok = idx_alm_ok && csel_ok && (cmd_b != '0);
            OP_ALM_CLR:   cmd_ok = idx_alm_ok;
            OP_SOFT_RST:  cmd_ok = 1'b1;
`ifdef ATS_IRQ_EN
            OP_IRQ_ACK:   cmd_ok = 1'b1;
`endif
            default:      cmd_ok = 1'b0;
        endcase
        exec_ok      = (state == ST_EXEC) && cmd_ok;
        cnt_override = exec_ok && (cmd_op == OP_CLK_STOP || cmd_op == OP_CLK_LOAD);
        if (!cmd_ok)                    resp_stat = 2'b10;
        else if (cmd_op == OP_CLK_READ) resp_stat = 2'b11;
        else                            resp_stat = 2'b01;
    end

    // Per-counter step size, and whether the counter actually advances this
    // cycle (a STOP/LOAD being executed on it suppresses the increment).
    always_comb begin
        for (int c = 0; c < NUM_CLOCKS; c++) begin
            cnt_step[c] = CLK_W'(1) << cnt_rate[c];
            cnt_adv[c]  = cnt_en[c] && !(cnt_override && sel_clk[c]);
        end
    end

    // An alarm fires when its counter advances past the target this cycle:
    // the modular distance from the old count to the target is 1..step, so
    // skipped values and wrap-around are both caught. Loads never advance.
    always_comb begin
        fire    = '0;
        alm_adv = '0;
        for (int a = 0; a < NUM_ALARMS; a++) begin
            alm_old[a]  = '0;
            alm_step[a] = '0;
            for (int c = 0; c < NUM_CLOCKS; c++) begin
                if (alm_clk[a] == 4'(c)) begin
                    alm_old[a]  = cnt[c];
                    alm_step[a] = cnt_step[c];
                    alm_adv[a]  = cnt_adv[c];
                end
            end
            alm_diff[a] = alm_val[a] - alm_old[a];
            fire[a]     = alm_en[a] && alm_adv[a] && (alm_diff[a] != '0) &&
                          (alm_diff[a] <= alm_step[a]);
        end
    end

    // Datapath. Ordering inside the block matters: counting and firing are
    // written first, then the executing command, so a command on a counter
    // or slot overrides the same-cycle increment/fire bookkeeping, and a
    // soft reset overrides everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_a    <= '0;
            cmd_b    <= '0;
            stat     <= '0;
            rdata    <= '0;
            cnt_en   <= '0;
            alm_en   <= '0;
            alm_loop <= '0;
            alm_tmr  <= '0;
            for (int c = 0; c < NUM_CLOCKS; c++) begin
                cnt[c]      <= '0;
                cnt_rate[c] <= '0;
            end
            for (int a = 0; a < NUM_ALARMS; a++) begin
                alm_val[a]  <= '0;
                alm_int[a]  <= '0;
                alm_clk[a]  <= '0;
                alm_hold[a] <= '0;
            end
`ifdef ATS_IRQ_EN
            irq <= 1'b0;
`endif
        end else begin
            if (state == ST_IDLE && req) begin
                cmd_a <= ctrl_a;
                cmd_b <= ctrl_b;
            end

            if (state == ST_EXEC) begin
                stat  <= resp_stat;
                rdata <= (cmd_ok && cmd_op == OP_CLK_READ) ? idx_cnt : '0;
            end else begin
                stat  <= '0;
                rdata <= '0;
            end

            for (int c = 0; c < NUM_CLOCKS; c++) begin
                if (cnt_adv[c]) cnt[c] <= cnt[c] + cnt_step[c];
            end

            for (int a = 0; a < NUM_ALARMS; a++) begin
                if (fire[a]) begin
                    alm_hold[a] <= HOLD_INIT;
                    if (!alm_loop[a])    alm_en[a]  <= 1'b0;
                    else if (alm_tmr[a]) alm_val[a] <= alm_val[a] + alm_int[a];
                end else if (alm_hold[a] != 4'd0) begin
                    alm_hold[a] <= alm_hold[a] - 4'd1;
                end
            end

`ifdef ATS_IRQ_EN
            // A fire in the same cycle as the acknowledge wins.
            if (exec_ok && cmd_op == OP_IRQ_ACK) irq <= 1'b0;
            if (|fire)                           irq <= 1'b1;
`endif

            if (exec_ok) begin
                case (cmd_op)
                    OP_CLK_START: for (int c = 0; c < NUM_CLOCKS; c++) begin
                        if (sel_clk[c]) begin
                            cnt_en[c]   <= 1'b1;
                            cnt_rate[c] <= cmd_rl;
                        end
                    end
                    OP_CLK_STOP: for (int c = 0; c < NUM_CLOCKS; c++) begin
                        if (sel_clk[c]) cnt_en[c] <= 1'b0;
                    end
                    OP_CLK_LOAD: for (int c = 0; c < NUM_CLOCKS; c++) begin
                        if (sel_clk[c]) cnt[c] <= cmd_b;
                    end
                    OP_ALM_SET, OP_TMR_SET: for (int a = 0; a < NUM_ALARMS; a++) begin
                        if (sel_alm[a]) begin
                            alm_en[a]   <= 1'b1;
                            alm_clk[a]  <= cmd_csel;
                            alm_loop[a] <= cmd_rl[0];
                            alm_int[a]  <= cmd_b;
                            alm_hold[a] <= '0;
                            alm_tmr[a]  <= (cmd_op == OP_TMR_SET);
                            alm_val[a]  <= (cmd_op == OP_TMR_SET) ? src_cnt + cmd_b : cmd_b;
                        end
                    end
                    OP_ALM_CLR: for (int a = 0; a < NUM_ALARMS; a++) begin
                        if (sel_alm[a]) begin
                            alm_en[a]   <= 1'b0;
                            alm_hold[a] <= '0;
                        end
                    end
                    OP_SOFT_RST: begin
                        cnt_en   <= '0;
                        alm_en   <= '0;
                        alm_loop <= '0;
                        alm_tmr  <= '0;
                        for (int c = 0; c < NUM_CLOCKS; c++) begin
                            cnt[c]      <= '0;
                            cnt_rate[c] <= '0;
                        end
                        for (int a = 0; a < NUM_ALARMS; a++) begin
                            alm_val[a]  <= '0;
                            alm_int[a]  <= '0;
                            alm_clk[a]  <= '0;
                            alm_hold[a] <= '0;
                        end
`ifdef ATS_IRQ_EN
                        irq <= 1'b0;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    // Flag is high while its hold counter is still running.
    always_comb begin
        data = '0;
        for (int a = 0; a < NUM_ALARMS; a++) begin
            data[a] = (alm_hold[a] != 4'd0);
        end
    end

endmodule

// File: tb/tb_ats_timer_bank.sv
// tb_ats_timer_bank
//   Randomised plus directed stimulus for ats_timer_bank. A reference model
//   of the bank (counters, alarm slots, flag timing, command protocol) is
//   stepped every clock; it pushes each expected response into a queue that
//   a separate monitor drains whenever the DUT shows a response. The monitor
//   also compares ready, the flag bus and (with ATS_IRQ_EN) irq every cycle.
module tb_ats_timer_bank;

    localparam int W    = 16;
    localparam int NC   = 16;
    localparam int NA   = 24;
    localparam int HOLD = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req = 1'b0;
    logic [15:0]   ctrl_a = '0;
    logic [W-1:0]  ctrl_b = '0;
    logic          ready;
    logic [1:0]    stat;
    logic [W-1:0]  rdata;
    logic [NA-1:0] data;
`ifdef ATS_IRQ_EN
    logic          irq;
`endif

    ats_timer_bank #(
        .CLK_W(W), .NUM_CLOCKS(NC), .NUM_ALARMS(NA), .FLAG_HOLD(HOLD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .ctrl_a(ctrl_a), .ctrl_b(ctrl_b),
        .ready(ready), .stat(stat), .rdata(rdata), .data(data)
`ifdef ATS_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_cnt  [NC];
    bit           m_en   [NC];
    int           m_step [NC];
    bit           a_en   [NA];
    bit           a_loop [NA];
    bit           a_tmr  [NA];
    logic [W-1:0] a_val  [NA];
    logic [W-1:0] a_int  [NA];
    int           a_clk  [NA];
    longint       a_fire [NA];
    bit           m_irq;
    int           m_busy;
    logic [15:0]  m_a;
    logic [W-1:0] m_b;
    longint       cyc = 0;

    typedef struct {
        logic [1:0]   st;
        logic [W-1:0] rd;
        longint       when;
    } resp_t;
    resp_t exp_q[$];

    // True if some value old+1 .. old+step (mod 2^W) equals target.
    function automatic bit passes(logic [W-1:0] old, int step, logic [W-1:0] target);
        logic [W-1:0] t;
        for (int k = 1; k <= step; k++) begin
            t = old + W'(k);
            if (t == target) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [1:0] expectStat(int op, int idx, int csel, int rl, logic [W-1:0] b);
        case (op)
            0:       return 2'b01;
            1:       return (idx < NC && rl != 3) ? 2'b01 : 2'b10;
            2, 3:    return (idx < NC) ? 2'b01 : 2'b10;
            4:       return (idx < NC) ? 2'b11 : 2'b10;
            5:       return (idx < NA && csel < NC) ? 2'b01 : 2'b10;
            6:       return (idx < NA && csel < NC && b != 0) ? 2'b01 : 2'b10;
            7:       return (idx < NA) ? 2'b01 : 2'b10;
            8:       return 2'b01;
`ifdef ATS_IRQ_EN
            9:       return 2'b01;
`endif
            default: return 2'b10;
        endcase
    endfunction

    task automatic modelClear();
        for (int c = 0; c < NC; c++) begin
            m_cnt[c] = '0; m_en[c] = 0; m_step[c] = 1;
        end
        for (int a = 0; a < NA; a++) begin
            a_en[a] = 0; a_loop[a] = 0; a_tmr[a] = 0;
            a_val[a] = '0; a_int[a] = '0; a_clk[a] = 0; a_fire[a] = -1000;
        end
        m_irq = 0;
    endtask

    task automatic modelStep();
        logic [W-1:0] old [NC];
        bit           fired [NA];
        bit           any, exec, ok;
        int           op, idx, csel, rl, ovr;
        logic [1:0]   st;
        logic [W-1:0] rd;
        cyc++;
        old  = m_cnt;
        exec = (m_busy == 2);
        op   = int'(m_a[15:12]);
        idx  = int'(m_a[11:6]);
        csel = int'(m_a[5:2]);
        rl   = int'(m_a[1:0]);
        st   = expectStat(op, idx, csel, rl, m_b);
        ok   = exec && (st != 2'b10);
        ovr  = (ok && (op == 2 || op == 3)) ? idx : -1;
        any  = 0;
        for (int a = 0; a < NA; a++) begin
            fired[a] = 0;
            if (a_en[a] && m_en[a_clk[a]] && a_clk[a] != ovr &&
                passes(old[a_clk[a]], m_step[a_clk[a]], a_val[a])) begin
                fired[a] = 1;
                any = 1;
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (m_en[c] && c != ovr) m_cnt[c] = old[c] + W'(m_step[c]);
        end
        for (int a = 0; a < NA; a++) begin
            if (fired[a]) begin
                a_fire[a] = cyc;
                if (!a_loop[a])   a_en[a]  = 0;
                else if (a_tmr[a]) a_val[a] = a_val[a] + a_int[a];
            end
        end
        if (any) m_irq = 1;
        if (exec) begin
            rd = '0;
            if (ok) begin
                case (op)
                    1: begin m_en[idx] = 1; m_step[idx] = 1 << rl; end
                    2: m_en[idx] = 0;
                    3: m_cnt[idx] = m_b;
                    4: rd = old[idx];
                    5, 6: begin
                        a_en[idx] = 1; a_clk[idx] = csel; a_loop[idx] = rl[0];
                        a_tmr[idx] = (op == 6); a_int[idx] = m_b; a_fire[idx] = -1000;
                        a_val[idx] = (op == 6) ? old[csel] + m_b : m_b;
                    end
                    7: begin a_en[idx] = 0; a_fire[idx] = -1000; end
                    8: modelClear();
                    9: if (!any) m_irq = 0;
                    default: ;
                endcase
            end
            exp_q.push_back('{st, rd, cyc});
        end
        if (m_busy == 2)      m_busy = 1;
        else if (m_busy == 1) m_busy = 0;
        else if (req) begin
            m_busy = 2;
            m_a    = ctrl_a;
            m_b    = ctrl_b;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            modelClear();
            m_busy = 0;
            exp_q.delete();
        end else begin
            modelStep();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [NA-1:0] exp_data;
        resp_t e;
        for (int a = 0; a < NA; a++) begin
            exp_data[a] = (cyc >= a_fire[a]) && (cyc - a_fire[a] < HOLD);
        end
        checkOutput("ready", 64'(ready), 64'(m_busy == 0));
        checkOutput("data", 64'(data), 64'(exp_data));
`ifdef ATS_IRQ_EN
        checkOutput("irq", 64'(irq), 64'(m_irq));
`endif
        if (stat != 2'b00 || (exp_q.size() > 0 && exp_q[0].when <= cyc)) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_stat", 64'(stat), 64'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("resp_stat", 64'(stat), 64'(e.st));
                checkOutput("resp_rdata", 64'(rdata), 64'(e.rd));
                checkOutput("resp_latency", 64'(cyc - e.when), 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic waitReady();
        int guard = 0;
        while (ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            tests++;
            fails++;
            $display("[TB] FAIL ready_timeout: ready stayed %b, required 1", ready);
        end
    endtask

    task automatic applyStimulus(input int op, input int idx, input int csel, input int rl,
                                 input logic [W-1:0] b);
        waitReady();
        ctrl_a = {4'(op), 6'(idx), 4'(csel), 2'(rl)};
        ctrl_b = b;
        req    = 1'b1;
        @(negedge clk);
        // Occasionally keep requesting while busy; the block must ignore it.
        if ($urandom_range(0, 3) == 0) begin
            ctrl_a = 16'($urandom);
            ctrl_b = W'($urandom);
            @(negedge clk);
        end
        req    = 1'b0;
        ctrl_a = 16'($urandom);
        ctrl_b = W'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic resetMidExec();
        waitReady();
        ctrl_a = {4'd1, 6'd0, 4'd0, 2'd1};
        ctrl_b = '0;
        req    = 1'b1;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        req     = 1'b0;
        #1;
        checkOutput("rst_ready", 64'(ready), 64'd1);
        checkOutput("rst_stat", 64'(stat), 64'd0);
        checkOutput("rst_rdata", 64'(rdata), 64'd0);
        checkOutput("rst_data", 64'(data), 64'd0);
`ifdef ATS_IRQ_EN
        checkOutput("rst_irq", 64'(irq), 64'd0);
`endif
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int op, idx, csel, rl;
        logic [W-1:0] b;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_stat", 64'(stat), 64'd0);
        checkOutput("reset_rdata", 64'(rdata), 64'd0);

        // Single-shot alarm at 10 on counter 0.
        applyStimulus(1, 0, 0, 0, '0);
        applyStimulus(5, 0, 0, 0, 16'd10);
        idle(15);

        // Wrap-and-skip: counter 1 from 0xFFFD by +4, alarm at 0.
        applyStimulus(3, 1, 0, 0, 16'hFFFD);
        applyStimulus(5, 3, 1, 0, 16'h0000);
        applyStimulus(1, 1, 0, 2, '0);
        idle(6);

        // Repeating timer, then cleared.
        applyStimulus(6, 5, 0, 1, 16'd5);
        idle(22);
        applyStimulus(7, 5, 0, 0, '0);
        idle(10);

        // Read back a loaded, stopped counter.
        applyStimulus(3, 2, 0, 0, 16'h1234);
        applyStimulus(4, 2, 0, 0, '0);

        // Error commands.
        applyStimulus(15, 0, 0, 0, '0);
        applyStimulus(1, 20, 0, 0, '0);
        applyStimulus(6, 4, 0, 1, '0);
        applyStimulus(5, 30, 0, 0, 16'd3);
        applyStimulus(1, 3, 0, 3, '0);
        applyStimulus(9, 0, 0, 0, '0);
        idle(4);

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 4)       op = $urandom_range(10, 15);
            else if (r < 5)  op = 8;
            else begin
                op = $urandom_range(0, 9);
                if (op == 8) op = 1;
            end
            if ($urandom_range(0, 9) == 0)      idx = $urandom_range(0, 63);
            else if (op >= 5 && op <= 7)        idx = $urandom_range(0, NA - 1);
            else                                idx = $urandom_range(0, NC - 1);
            csel = $urandom_range(0, NC - 1);
            rl   = $urandom_range(0, 3);
            case (op)
                6:       b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 12));
                5:       b = m_cnt[csel] + W'($urandom_range(1, 30));
                3:       b = ($urandom_range(0, 1) == 1) ? 16'hFFF0 + W'($urandom_range(0, 15))
                                                        : W'($urandom);
                default: b = W'($urandom);
            endcase
            applyStimulus(op, idx, csel, rl, b);
            idle($urandom_range(0, 4));
        end

        // Reset in the middle of a command, then show the block recovers.
        resetMidExec();
        applyStimulus(1, 0, 0, 0, '0);
        applyStimulus(5, 0, 0, 1, 16'd8);
        applyStimulus(4, 0, 0, 0, '0);
        idle(20);

        checkOutput("pending_resp", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
